// File: rtl/rename_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rename_pkg
//  Description : Shared constants, FSM encoding and bank-index helper for the
//                rename freelist allocation controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package rename_pkg;

    localparam int NBANK = 4;
    localparam int PREGW = 7;
    localparam int BANKW = $clog2(NBANK);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_FLUSH   = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    // A physical tag lives in the bank selected by its low index bits.
    function automatic logic [BANKW-1:0] bank_of(input logic [PREGW-1:0] preg);
        return preg[BANKW-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rename_alloc_ctrl_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Round-robin scan of a bank empty mask from a start pointer,
//                returning the first and second non-empty banks.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 #(
    parameter int NBANK = 4,
    parameter int BW    = $clog2(NBANK)
) (
    input  logic [NBANK-1:0] i_empty,
    input  logic [BW-1:0]    i_start,
    output logic             o_first_vld,
    output logic [BW-1:0]    o_first_idx,
    output logic             o_second_vld,
    output logic [BW-1:0]    o_second_idx
);

    logic [BW-1:0] w_idx;

    // Walk banks start, start+1, ... (wrapping); take the first two non-empty.
    always_comb begin
        o_first_vld  = 1'b0;
        o_first_idx  = '0;
        o_second_vld = 1'b0;
        o_second_idx = '0;
        w_idx        = '0;
        for (int k = 0; k < NBANK; k++) begin
            w_idx = i_start + BW'(k);
            if (!i_empty[w_idx]) begin
                if (!o_first_vld) begin
                    o_first_vld = 1'b1;
                    o_first_idx = w_idx;
                end else if (!o_second_vld) begin
                    o_second_vld = 1'b1;
                    o_second_idx = w_idx;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rename_alloc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rename_alloc_ctrl
//  Description : Shares four rename freelist banks between two rename lanes:
//                round-robin allocation from distinct banks, commit release
//                routing to the owning bank, and flush/clean/settle recovery.
//  Revision    : 1.0 - initial release
// ============================================================================
module rename_alloc_ctrl
    import rename_pkg::*;
#(
    parameter int NBANK      = rename_pkg::NBANK,
    parameter int PREGW      = rename_pkg::PREGW,
    parameter int FLUSH_WAIT = 2
) (
    input  logic                   Clk,
    input  logic                   Rest,
    input  logic [1:0]             AllocReq,
    output logic [1:0]             AllocGnt,
    output logic [2*PREGW-1:0]     AllocPreg,
    output logic                   AllocStall,
    input  logic [NBANK*PREGW-1:0] BankPreOut,
    input  logic [NBANK-1:0]       BankEmpty,
    output logic [NBANK-1:0]       BankRable,
    input  logic [1:0]             RelValid,
    input  logic [2*PREGW-1:0]     RelPreg,
    output logic [1:0]             RelReady,
    output logic [NBANK-1:0]       BankWable,
    output logic [NBANK*PREGW-1:0] BankDin,
    input  logic                   FlushReq,
    output logic [NBANK-1:0]       BankClean,
    output logic                   Busy
);

    localparam int c_BW    = $clog2(NBANK);
    localparam int c_WAITW = (FLUSH_WAIT > 0) ? $clog2(FLUSH_WAIT + 1) : 1;
    localparam logic [c_WAITW-1:0] c_WAIT_INIT = c_WAITW'(FLUSH_WAIT);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_BW-1:0]    r_rr_ptr;
    logic [c_BW-1:0]    w_rr_nxt;
    logic [c_WAITW-1:0] r_wait_cnt;
    logic [c_WAITW-1:0] w_wait_nxt;

    logic               w_run;
    logic               w_flush;
    logic               w_first_vld;
    logic [c_BW-1:0]    w_first_idx;
    logic               w_second_vld;
    logic [c_BW-1:0]    w_second_idx;
    logic [1:0]         w_gnt;
    logic [c_BW-1:0]    w_lane_bank [2];
    logic [c_BW-1:0]    w_rel_bank  [2];
    logic [1:0]         w_rel_acc;

    // Outputs are gated by Rest so they drop as soon as reset is asserted.
    assign w_run   = (r_state == ST_RUN)   && !Rest;
    assign w_flush = (r_state == ST_FLUSH) && !Rest;

    rr_pick2 #(
        .NBANK (NBANK),
        .BW    (c_BW)
    ) u_pick (
        .i_empty      (BankEmpty),
        .i_start      (r_rr_ptr),
        .o_first_vld  (w_first_vld),
        .o_first_idx  (w_first_idx),
        .o_second_vld (w_second_vld),
        .o_second_idx (w_second_idx)
    );

    // Lane grants: an idle lane 0 hands its scan slot to lane 1 (in-order rule).
    always_comb begin
        w_gnt          = 2'b00;
        w_lane_bank[0] = w_first_idx;
        w_lane_bank[1] = AllocReq[0] ? w_second_idx : w_first_idx;
        if (w_run) begin
            if (AllocReq[0]) begin
                w_gnt[0] = w_first_vld;
                w_gnt[1] = AllocReq[1] && w_first_vld && w_second_vld;
            end else begin
                w_gnt[1] = AllocReq[1] && w_first_vld;
            end
        end
    end

    // Pop strobes and tag muxing for the granted lanes.
    always_comb begin
        AllocGnt  = w_gnt;
        AllocPreg = '0;
        BankRable = '0;
        for (int l = 0; l < 2; l++) begin
            if (w_gnt[l]) begin
                BankRable[w_lane_bank[l]]       = 1'b1;
                AllocPreg[l*PREGW +: PREGW]     = BankPreOut[w_lane_bank[l]*PREGW +: PREGW];
            end
        end
        AllocStall = !Rest && (|(AllocReq & ~w_gnt));
    end

    // Release routing: lane 1 yields when lane 0 hits the same bank.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            w_rel_bank[l] = bank_of(RelPreg[l*PREGW +: PREGW]);
        end
        RelReady[0] = w_run;
        RelReady[1] = w_run && !(RelValid[0] && (w_rel_bank[0] == w_rel_bank[1]));
        w_rel_acc   = RelValid & RelReady;
        BankWable   = '0;
        BankDin     = '0;
        for (int l = 0; l < 2; l++) begin
            if (w_rel_acc[l]) begin
                BankWable[w_rel_bank[l]]               = 1'b1;
                BankDin[w_rel_bank[l]*PREGW +: PREGW]  = RelPreg[l*PREGW +: PREGW];
            end
        end
    end

    // Flush status outputs.
    always_comb begin
        BankClean = {NBANK{w_flush}};
        Busy      = (r_state != ST_RUN) && !Rest;
    end

    // Next-state, settle counter and round-robin pointer.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_rr_nxt    = r_rr_ptr;
        if (w_gnt[1]) begin
            w_rr_nxt = w_lane_bank[1] + c_BW'(1);
        end else if (w_gnt[0]) begin
            w_rr_nxt = w_lane_bank[0] + c_BW'(1);
        end
        case (r_state)
            ST_RUN: begin
                if (FlushReq) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_rr_nxt    = '0;
                w_wait_nxt  = c_WAIT_INIT;
                w_state_nxt = (FLUSH_WAIT == 0) ? ST_RUN : ST_RECOVER;
            end
            ST_RECOVER: begin
                if (r_wait_cnt != '0) begin
                    w_wait_nxt = r_wait_cnt - c_WAITW'(1);
                end
                if (FlushReq) begin
                    w_state_nxt = ST_FLUSH;
                end else if (r_wait_cnt <= c_WAITW'(1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            r_state    <= ST_RUN;
            r_rr_ptr   <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rename_alloc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rename_alloc_ctrl
//  Description : Directed self-checking bench for rename_alloc_ctrl using an
//                expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_alloc_ctrl;

    localparam int NBANK = 4;
    localparam int PREGW = 7;

    logic                   Clk;
    logic                   Rest;
    logic [1:0]             AllocReq;
    logic [1:0]             AllocGnt;
    logic [2*PREGW-1:0]     AllocPreg;
    logic                   AllocStall;
    logic [NBANK*PREGW-1:0] BankPreOut;
    logic [NBANK-1:0]       BankEmpty;
    logic [NBANK-1:0]       BankRable;
    logic [1:0]             RelValid;
    logic [2*PREGW-1:0]     RelPreg;
    logic [1:0]             RelReady;
    logic [NBANK-1:0]       BankWable;
    logic [NBANK*PREGW-1:0] BankDin;
    logic                   FlushReq;
    logic [NBANK-1:0]       BankClean;
    logic                   Busy;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [13:0] preg;
        logic        stall;
        logic [3:0]  rable;
        logic [1:0]  rready;
        logic [3:0]  wable;
        logic [27:0] din;
        logic [3:0]  clean;
        logic        busy;
    } exp_t;

    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step    = 0;

    rename_alloc_ctrl #(
        .NBANK      (NBANK),
        .PREGW      (PREGW),
        .FLUSH_WAIT (2)
    ) dut (
        .Clk        (Clk),
        .Rest       (Rest),
        .AllocReq   (AllocReq),
        .AllocGnt   (AllocGnt),
        .AllocPreg  (AllocPreg),
        .AllocStall (AllocStall),
        .BankPreOut (BankPreOut),
        .BankEmpty  (BankEmpty),
        .BankRable  (BankRable),
        .RelValid   (RelValid),
        .RelPreg    (RelPreg),
        .RelReady   (RelReady),
        .BankWable  (BankWable),
        .BankDin    (BankDin),
        .FlushReq   (FlushReq),
        .BankClean  (BankClean),
        .Busy       (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog step=%0d observed=timeout expected=finish", step);
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic [1:0] gnt, input int p1, input int p0,
                                input logic stall, input logic [3:0] rable,
                                input logic [1:0] rready, input logic [3:0] wable,
                                input logic [27:0] din, input logic [3:0] clean,
                                input logic busy);
        exp_t e;
        e.gnt    = gnt;
        e.preg   = {7'(p1), 7'(p0)};
        e.stall  = stall;
        e.rable  = rable;
        e.rready = rready;
        e.wable  = wable;
        e.din    = din;
        e.clean  = clean;
        e.busy   = busy;
        return e;
    endfunction

    function automatic logic [27:0] dinv(input int b3, input int b2, input int b1, input int b0);
        return {7'(b3), 7'(b2), 7'(b1), 7'(b0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard step=%0d observed=empty expected=entry", step);
            return;
        end
        e = sb.pop_front();
        check("gnt",    32'(AllocGnt),   32'(e.gnt));
        check("preg",   32'(AllocPreg),  32'(e.preg));
        check("stall",  32'(AllocStall), 32'(e.stall));
        check("rable",  32'(BankRable),  32'(e.rable));
        check("rready", 32'(RelReady),   32'(e.rready));
        check("wable",  32'(BankWable),  32'(e.wable));
        check("din",    32'(BankDin),    32'(e.din));
        check("clean",  32'(BankClean),  32'(e.clean));
        check("busy",   32'(Busy),       32'(e.busy));
    endtask

    task automatic drv(input logic [1:0] req, input logic [3:0] empty, input logic [1:0] rv,
                       input int r1, input int r0, input logic fl);
        step++;
        AllocReq  = req;
        BankEmpty = empty;
        RelValid  = rv;
        RelPreg   = {7'(r1), 7'(r0)};
        FlushReq  = fl;
    endtask

    task automatic cycle_check();
        @(negedge Clk);
        compare_pop();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rest       = 1'b1;
        BankPreOut = {7'd126, 7'd122, 7'd118, 7'd114};
        drv(2'b11, 4'b0000, 2'b11, 71, 34, 1'b1);
        #12;
        sb.push_back(mk(2'b00, 0, 0, 1'b0, 4'b0000, 2'b00, 4'b0000, 28'd0, 4'b0000, 1'b0));
        compare_pop();
        @(negedge Clk);
        Rest = 1'b0;
        drv(2'b00, 4'b0000, 2'b00, 0, 0, 1'b0);
        @(posedge Clk);
        #1;

        // Allocation patterns
        drv(2'b11, 4'b0000, 2'b00, 0, 0, 1'b0);
        sb.push_back(mk(2'b11, 118, 114, 1'b0, 4'b0011, 2'b11, 4'b0000, 28'd0, 4'b0000, 1'b0));
        cycle_check();
        drv(2'b11, 4'b0100, 2'b00, 0, 0, 1'b0);
        sb.push_back(mk(2'b11, 114, 126, 1'b0, 4'b1001, 2'b11, 4'b0000, 28'd0, 4'b0000, 1'b0));
        cycle_check();
        drv(2'b11, 4'b1101, 2'b00, 0, 0, 1'b0);
        sb.push_back(mk(2'b01, 0, 118, 1'b1, 4'b0010, 2'b11, 4'b0000, 28'd0, 4'b0000, 1'b0));
        cycle_check();
        drv(2'b10, 4'b1111, 2'b00, 0, 0, 1'b0);
        sb.push_back(mk(2'b00, 0, 0, 1'b1, 4'b0000, 2'b11, 4'b0000, 28'd0, 4'b0000, 1'b0));
        cycle_check();
        drv(2'b10, 4'b0000, 2'b00, 0, 0, 1'b0);
        sb.push_back(mk(2'b10, 122, 0, 1'b0, 4'b0100, 2'b11, 4'b0000, 28'd0, 4'b0000, 1'b0));
        cycle_check();

        // Releases (same bank conflict, then distinct banks with same-bank alloc)
        drv(2'b00, 4'b0000, 2'b11, 70, 34, 1'b0);
        sb.push_back(mk(2'b00, 0, 0, 1'b0, 4'b0000, 2'b01, 4'b0100, dinv(0, 34, 0, 0), 4'b0000, 1'b0));
        cycle_check();
        drv(2'b01, 4'b0000, 2'b11, 71, 34, 1'b0);
        sb.push_back(mk(2'b01, 0, 126, 1'b0, 4'b1000, 2'b11, 4'b1100, dinv(71, 34, 0, 0), 4'b0000, 1'b0));
        cycle_check();

        // Flush: request cycle still grants, then FLUSH, RECOVER x2, RUN from bank0
        drv(2'b11, 4'b0000, 2'b00, 0, 0, 1'b1);
        sb.push_back(mk(2'b11, 118, 114, 1'b0, 4'b0011, 2'b11, 4'b0000, 28'd0, 4'b0000, 1'b0));
        cycle_check();
        drv(2'b11, 4'b0000, 2'b11, 71, 34, 1'b0);
        sb.push_back(mk(2'b00, 0, 0, 1'b1, 4'b0000, 2'b00, 4'b0000, 28'd0, 4'b1111, 1'b1));
        cycle_check();
        drv(2'b11, 4'b0000, 2'b11, 71, 34, 1'b0);
        sb.push_back(mk(2'b00, 0, 0, 1'b1, 4'b0000, 2'b00, 4'b0000, 28'd0, 4'b0000, 1'b1));
        cycle_check();
        drv(2'b11, 4'b0000, 2'b11, 71, 34, 1'b0);
        sb.push_back(mk(2'b00, 0, 0, 1'b1, 4'b0000, 2'b00, 4'b0000, 28'd0, 4'b0000, 1'b1));
        cycle_check();
        drv(2'b11, 4'b0000, 2'b11, 71, 34, 1'b0);
        sb.push_back(mk(2'b11, 118, 114, 1'b0, 4'b0011, 2'b11, 4'b1100, dinv(71, 34, 0, 0), 4'b0000, 1'b0));
        cycle_check();

        // Re-flush from RECOVER; flush request during FLUSH is ignored
        drv(2'b00, 4'b0000, 2'b00, 0, 0, 1'b1);
        sb.push_back(mk(2'b00, 0, 0, 1'b0, 4'b0000, 2'b11, 4'b0000, 28'd0, 4'b0000, 1'b0));
        cycle_check();
        drv(2'b00, 4'b0000, 2'b00, 0, 0, 1'b0);
        sb.push_back(mk(2'b00, 0, 0, 1'b0, 4'b0000, 2'b00, 4'b0000, 28'd0, 4'b1111, 1'b1));
        cycle_check();
        drv(2'b00, 4'b0000, 2'b00, 0, 0, 1'b1);
        sb.push_back(mk(2'b00, 0, 0, 1'b0, 4'b0000, 2'b00, 4'b0000, 28'd0, 4'b0000, 1'b1));
        cycle_check();
        drv(2'b00, 4'b0000, 2'b00, 0, 0, 1'b1);
        sb.push_back(mk(2'b00, 0, 0, 1'b0, 4'b0000, 2'b00, 4'b0000, 28'd0, 4'b1111, 1'b1));
        cycle_check();
        drv(2'b01, 4'b0000, 2'b00, 0, 0, 1'b0);
        sb.push_back(mk(2'b00, 0, 0, 1'b1, 4'b0000, 2'b00, 4'b0000, 28'd0, 4'b0000, 1'b1));
        cycle_check();
        drv(2'b01, 4'b0000, 2'b00, 0, 0, 1'b0);
        sb.push_back(mk(2'b00, 0, 0, 1'b1, 4'b0000, 2'b00, 4'b0000, 28'd0, 4'b0000, 1'b1));
        cycle_check();
        drv(2'b11, 4'b0000, 2'b00, 0, 0, 1'b0);
        sb.push_back(mk(2'b11, 118, 114, 1'b0, 4'b0011, 2'b11, 4'b0000, 28'd0, 4'b0000, 1'b0));
        cycle_check();

        // Asynchronous reset in the middle of a granting cycle
        drv(2'b11, 4'b0000, 2'b11, 71, 34, 1'b0);
        sb.push_back(mk(2'b11, 126, 122, 1'b0, 4'b1100, 2'b11, 4'b1100, dinv(71, 34, 0, 0), 4'b0000, 1'b0));
        @(negedge Clk);
        compare_pop();
        #2;
        Rest = 1'b1;
        #1;
        step++;
        sb.push_back(mk(2'b00, 0, 0, 1'b0, 4'b0000, 2'b00, 4'b0000, 28'd0, 4'b0000, 1'b0));
        compare_pop();
        @(posedge Clk);
        #3;
        Rest = 1'b0;
        drv(2'b11, 4'b0000, 2'b00, 0, 0, 1'b0);
        sb.push_back(mk(2'b11, 118, 114, 1'b0, 4'b0011, 2'b11, 4'b0000, 28'd0, 4'b0000, 1'b0));
        cycle_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rename_alloc_ctrl.md
Name: rename_alloc_ctrl

Overview:
- Controller sharing four rename freelist banks between two decode/rename lanes.
- Bank b holds free physical registers whose preg[1:0] == b.
- Per cycle, grants up to two allocations from distinct banks via round-robin, routes commit releases back to their owning bank, and sequences flush recovery with clean pulse, settle wait and resume.
- Sits between decode lanes, the four freelist banks and the commit/flush logic.

Parameters:
- NBANK, 4, number of freelist banks (power of 2; bank index = low log2(NBANK) preg bits).
- PREGW, 7, physical register tag width.
- FLUSH_WAIT, 2, settle cycles after the bank clean pulse before allocation resumes.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rest  in  1  asynchronous, active-high reset.
- AllocReq  in  2  per-lane allocation request; lane 0 is older.
- AllocGnt  out  2  per-lane grant, same cycle as the request.
- AllocPreg  out  2*PREGW  granted tag; lane0 in [PREGW-1:0].
- AllocStall  out  1  a requesting lane was not granted this cycle.
- BankPreOut  in  NBANK*PREGW  head tag of each bank (combinational peek).
- BankEmpty  in  NBANK  bank empty flags.
- BankRable  out  NBANK  pop strobe per bank.
- RelValid  in  2  commit release valid per lane.
- RelPreg  in  2*PREGW  released tags.
- RelReady  out  2  release accepted this cycle.
- BankWable  out  NBANK  push strobe per bank.
- BankDin  out  NBANK*PREGW  push data per bank.
- FlushReq  in  1  pipeline flush request.
- BankClean  out  NBANK  clean pulse to all banks.
- Busy  out  1  high when state != RUN.

Behaviour:
- State: FSM {RUN, FLUSH, RECOVER}, 2-bit RrPtr, counter WaitCnt of width clog2(FLUSH_WAIT+1).
- Reset (Rest high, asynchronous): state=RUN, RrPtr=0, WaitCnt=0. While Rest is high, all outputs are forced to 0.
- Allocation is combinational, zero latency, and only in RUN.
- Lane0 candidate: first bank b with BankEmpty[b]=0, scanning RrPtr, RrPtr+1, ... mod NBANK.
- Lane1 candidate: the next non-empty bank after lane0's candidate, scanning mod NBANK, excluding lane0's bank.
- In-order rule: lane1 is granted only if lane1 requests, has a candidate, and lane0 is either granted or not requesting. If lane0 does not request, lane1 takes lane0's scan slot.
- Grants drive BankRable[bank]=1 and AllocPreg = BankPreOut[bank] for the granted lane; ungranted lanes output AllocPreg=0.
- AllocStall = |(AllocReq & ~AllocGnt).
- RrPtr update: on any grant, RrPtr <= (last granted bank + 1) mod NBANK; otherwise it holds.
- Release routing: bank = RelPreg[lane][1:0].
- Lane0 is always ready in RUN.
- Lane1 is ready in RUN unless lane0 is valid and targets the same bank.
- Accepted releases drive BankWable[bank]=1 and BankDin[bank]=RelPreg. Undriven BankDin lanes output 0.
- Release and allocation on the same bank in the same cycle are both allowed (the bank tolerates Rable with Wable).
- Transition RUN -> FLUSH when FlushReq=1. The flush cycle itself still grants and releases normally.
- FLUSH lasts one cycle: BankClean all-ones; AllocGnt, RelReady, BankRable and BankWable all 0. RrPtr <= 0, WaitCnt <= FLUSH_WAIT, then go to RECOVER.
- RECOVER: no grants and no releases. WaitCnt decrements each cycle; go to RUN when WaitCnt==1, or immediately if FLUSH_WAIT==0.
- FlushReq in RECOVER returns to FLUSH. FlushReq in FLUSH is ignored.
- Busy = (state != RUN).
- When FLUSH_WAIT=2, total unavailability after a flush is 3 cycles (FLUSH, RECOVER, RECOVER).

Decomposition:
- Shared package rename_pkg holds: NBANK, PREGW, the state encoding (ST_RUN=0, ST_FLUSH=1, ST_RECOVER=2), and the bank index function bank_of(preg)=preg[1:0].
- One natural sub-module, rr_pick2: given the NBANK empty mask and a start pointer, it returns the first and second non-empty banks with valid bits. It is purely combinational and reused for verification as a reference model.

Test Plan:
- Reset, then AllocReq=2'b11 with all banks non-empty and PreOut = {126,122,118,114}: grants lane0 bank0 (114) and lane1 bank1 (118); BankRable=0011; next RrPtr=2.
- RrPtr=2, BankEmpty=0100, AllocReq=11: lane0 gets bank3, lane1 gets bank0; RrPtr becomes 1.
- Only bank1 non-empty, AllocReq=11: lane0 granted bank1, lane1 not granted, AllocStall=1.
- All banks empty, AllocReq=10: lane1 not granted (no candidate), AllocStall=1.
- RelValid=11 with RelPreg={70,34} (both bank2): RelReady=01, BankWable=0100, BankDin[2]=34.
- RelValid=11 with RelPreg={71,34}: both ready, BankWable=1100.
- FlushReq pulse in RUN: next cycle BankClean=1111 with grants blocked. Busy is high for 3 cycles, allocation resumes on cycle 4 from bank0. A second FlushReq during RECOVER re-enters FLUSH.
- Assert Rest asynchronously mid-grant: all outputs drop to 0 immediately; after release, state=RUN and RrPtr=0.
